// File: rtl/pito_test_ctrl_if.sv
// rtl/pito_test_ctrl_if.sv - APB bus bundle between the SoC peripheral bus and pito_test_ctrl
interface pito_test_ctrl_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;
   logic                  pslverr;

   modport master (output psel, penable, pwrite, paddr, pwdata,
                   input  prdata, pready, pslverr);
   modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                   output prdata, pready, pslverr);
endinterface

// File: rtl/pito_test_ctrl.sv
// rtl/pito_test_ctrl.sv - end-of-test controller: per-hart pass/fail, stall detection, watchdog
module pito_test_ctrl #(
   parameter int NUM_HARTS       = 8,
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int STALL_LIMIT     = 4096,
   parameter int DEFAULT_TIMEOUT = 1000000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_HARTS-1:0]  hart_en,
   input  logic [NUM_HARTS-1:0]  hart_retire,
   pito_test_ctrl_if.slave       apb,
   output logic                  test_done,
   output logic                  test_pass,
   output logic                  test_timeout,
   output logic [2:0]            fail_hart,
   output logic [DATA_WIDTH-2:0] fail_code
);
   localparam int CW = $clog2(STALL_LIMIT + 1);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_PASS    = 2'd1,
      ST_FAIL    = 2'd2,
      ST_TIMEOUT = 2'd3
   } state_t;

   state_t                state;
   logic [NUM_HARTS-1:0]  done;
   logic [NUM_HARTS-1:0]  pass;
   logic [NUM_HARTS-1:0]  done_n;
   logic [NUM_HARTS-1:0]  pass_n;
   logic [NUM_HARTS-1:0]  stall_inc;
   logic [CW-1:0]         stall_cnt [NUM_HARTS];
   logic [DATA_WIDTH-1:0] cycles;
   logic [DATA_WIDTH-1:0] timeout;
   logic [7:0]            addr;
   logic [7:0]            done8;
   logic [7:0]            pass8;
   logic                  access;
   logic                  wr;
   logic                  rd;
   logic                  is_tohost;
   logic                  is_status;
   logic                  is_timeout;
   logic                  is_cycles;
   logic                  mapped;
   logic                  tohost_fail;
   logic                  stall_fail;
   logic                  all_pass;
   logic                  timeout_hit;
   logic [2:0]            tohost_hart;
   logic [2:0]            stall_hart;

   assign addr       = apb.paddr[7:0];
   assign access     = apb.psel & apb.penable;
   assign wr         = access & apb.pwrite;
   assign rd         = access & ~apb.pwrite;
   // TOHOST slots are word aligned and only exist for implemented harts
   assign is_tohost  = (addr[7:5] == 3'd0) && (addr[1:0] == 2'd0) &&
                       ({29'd0, addr[4:2]} < NUM_HARTS);
   assign is_status  = (addr == 8'h20);
   assign is_timeout = (addr == 8'h24);
   assign is_cycles  = (addr == 8'h28);
   assign mapped     = is_tohost | is_status | is_timeout | is_cycles;

   assign apb.pready  = 1'b1;
   assign apb.pslverr = access & ~mapped;

   assign done8 = 8'(done);
   assign pass8 = 8'(pass);

   // Read mux: data only during a read access phase, zero otherwise
   always_comb begin
      apb.prdata = '0;
      if (rd) begin
         if (is_status)
            apb.prdata = DATA_WIDTH'({state, pass8, done8});
         else if (is_timeout)
            apb.prdata = timeout;
         else if (is_cycles)
            apb.prdata = cycles;
      end
   end

   // Next done/pass flags, TOHOST fail detection and lowest-index stall detection
   always_comb begin
      done_n      = done;
      pass_n      = pass;
      stall_inc   = '0;
      tohost_fail = 1'b0;
      tohost_hart = '0;
      stall_fail  = 1'b0;
      stall_hart  = '0;
      for (int h = 0; h < NUM_HARTS; h++) begin
         if (wr && state == ST_RUN && is_tohost && addr[4:2] == 3'(h) &&
             apb.pwdata[0] && !done[h]) begin
            done_n[h] = 1'b1;
            pass_n[h] = (apb.pwdata == DATA_WIDTH'(1));
            if (apb.pwdata != DATA_WIDTH'(1) && hart_en[h]) begin
               tohost_fail = 1'b1;
               tohost_hart = 3'(h);
            end
         end
      end
      // Descending scan so the lowest stalled hart is the one reported
      for (int h = NUM_HARTS - 1; h >= 0; h--) begin
         stall_inc[h] = (state == ST_RUN) && hart_en[h] && !done[h] && !hart_retire[h];
         if (stall_inc[h] && stall_cnt[h] == CW'(STALL_LIMIT - 1)) begin
            stall_fail = 1'b1;
            stall_hart = 3'(h);
         end
      end
   end

   // PASS includes a pass write landing this cycle; no enabled harts means no PASS
   assign all_pass    = (hart_en != '0) && ((hart_en & done_n & pass_n) == hart_en);
   assign timeout_hit = (timeout != '0) &&
                        (({1'b0, cycles} + (DATA_WIDTH + 1)'(1)) >= {1'b0, timeout});

   // Test FSM with registered terminal outputs, counters and hart flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_RUN;
         done         <= '0;
         pass         <= '0;
         cycles       <= '0;
         timeout      <= DATA_WIDTH'(DEFAULT_TIMEOUT);
         test_done    <= 1'b0;
         test_pass    <= 1'b0;
         test_timeout <= 1'b0;
         fail_hart    <= '0;
         fail_code    <= '0;
         for (int h = 0; h < NUM_HARTS; h++)
            stall_cnt[h] <= '0;
      end else begin
         if (wr && is_timeout)
            timeout <= apb.pwdata;
         if (state == ST_RUN) begin
            done <= done_n;
            pass <= pass_n;
            if (cycles != '1)
               cycles <= cycles + 1'b1;
            for (int h = 0; h < NUM_HARTS; h++) begin
               if (hart_retire[h])
                  stall_cnt[h] <= '0;
               else if (stall_inc[h])
                  stall_cnt[h] <= stall_cnt[h] + 1'b1;
            end
            if (tohost_fail) begin
               state     <= ST_FAIL;
               test_done <= 1'b1;
               fail_hart <= tohost_hart;
               fail_code <= apb.pwdata[DATA_WIDTH-1:1];
            end else if (stall_fail) begin
               state     <= ST_FAIL;
               test_done <= 1'b1;
               fail_hart <= stall_hart;
               fail_code <= '1;
            end else if (all_pass) begin
               state     <= ST_PASS;
               test_done <= 1'b1;
               test_pass <= 1'b1;
            end else if (timeout_hit) begin
               state        <= ST_TIMEOUT;
               test_done    <= 1'b1;
               test_timeout <= 1'b1;
            end
         end
      end
   end
endmodule
